unsigned_divider: RTL and testbench



---
 rtl/unsigned_divider_if.sv | 24 ++
 rtl/unsigned_divider.sv | 102 ++++++++++
 tb/tb_unsigned_divider.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/unsigned_divider_if.sv
// Start/finish handshake bundle for the sequential unsigned divider.
interface unsigned_divider_if #(
  parameter int N = 4
);
  logic         start;
  logic [N-1:0] A_in;
  logic [N-1:0] B_in;
  logic [N-1:0] quotient_out;
  logic [N-1:0] remainder_out;
  logic         finish;
  logic         div_by_zero;

  modport master (
    output start, A_in, B_in,
    input  quotient_out, remainder_out,
    input  finish, div_by_zero
  );

  modport slave (
    input  start, A_in, B_in,
    output quotient_out, remainder_out,
    output finish, div_by_zero
  );
endinterface

// File: rtl/unsigned_divider.sv
// Restoring unsigned divider, one quotient bit per clock, MSB first.
// UNSIGNED_DIVIDER_EARLY_TERM_EN: finish in one edge when B > A.
module unsigned_divider #(
  parameter int N = 4
) (
  input logic             clk,
  input logic             reset,
  unsigned_divider_if.slave bus
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FAST
  } state_t;

  state_t        state;
  logic [N-1:0]  dvd;
  logic [N-1:0]  dvs;
  logic [N-1:0]  quo;
  logic [N:0]    rem;
  logic [CW-1:0] cnt;
  logic          zero;

  logic [N:0]    shf;
  logic [N:0]    trial;
  logic [N:0]    rem_nx;
  logic          qbit;
  logic          short_cut;

  always_comb begin
    shf    = {rem[N-1:0], dvd[N-1]};
    trial  = shf - {1'b0, dvs};
    qbit   = ~trial[N];
    rem_nx = qbit ? trial : shf;
  end

  // Operands that need no iterations finish on the very next edge.
  always_comb begin
    short_cut = (bus.B_in == '0);
`ifdef UNSIGNED_DIVIDER_EARLY_TERM_EN
    if (bus.B_in > bus.A_in) begin
      short_cut = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      dvd               <= '0;
      dvs               <= '0;
      quo               <= '0;
      rem               <= '0;
      cnt               <= '0;
      zero              <= 1'b0;
      bus.quotient_out  <= '0;
      bus.remainder_out <= '0;
      bus.finish        <= 1'b1;
      bus.div_by_zero   <= 1'b0;
    end else if (bus.start) begin
      dvd               <= bus.A_in;
      dvs               <= bus.B_in;
      quo               <= '0;
      rem               <= '0;
      cnt               <= '0;
      zero              <= (bus.B_in == '0);
      bus.quotient_out  <= '0;
      bus.remainder_out <= '0;
      bus.finish        <= 1'b0;
      bus.div_by_zero   <= 1'b0;
      state             <= short_cut ? FAST : BUSY;
    end else begin
      unique case (state)
        IDLE: begin
        end
        BUSY: begin
          rem <= rem_nx;
          dvd <= {dvd[N-2:0], 1'b0};
          quo <= {quo[N-2:0], qbit};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N-1)) begin
            bus.quotient_out  <= {quo[N-2:0], qbit};
            bus.remainder_out <= rem_nx[N-1:0];
            bus.finish        <= 1'b1;
            state             <= IDLE;
          end
        end
        FAST: begin
          // Divide by zero yields all ones; B > A yields zero.
          bus.quotient_out  <= {N{zero}};
          bus.remainder_out <= dvd;
          bus.div_by_zero   <= zero;
          bus.finish        <= 1'b1;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_unsigned_divider.sv
// Directed bench for unsigned_divider with an arithmetic reference model.
module tb_unsigned_divider;
  localparam int N = 4;
`ifdef UNSIGNED_DIVIDER_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  unsigned_divider_if #(.N(N)) bus ();

  unsigned_divider #(.N(N)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  logic         m_fin, m_dbz, p_dbz;
  logic [N-1:0] m_q, m_r, p_q, p_r;
  int           m_left;

  // Reference: results are plain / and %, released after a countdown.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fin  <= 1'b1;
      m_q    <= '0;
      m_r    <= '0;
      m_dbz  <= 1'b0;
      m_left <= 0;
    end else if (bus.start) begin
      m_fin <= 1'b0;
      m_q   <= '0;
      m_r   <= '0;
      m_dbz <= 1'b0;
      if (bus.B_in == 0) begin
        p_q    <= '1;
        p_r    <= bus.A_in;
        p_dbz  <= 1'b1;
        m_left <= 1;
      end else begin
        p_q    <= bus.A_in / bus.B_in;
        p_r    <= bus.A_in % bus.B_in;
        p_dbz  <= 1'b0;
        m_left <= (EARLY && bus.B_in > bus.A_in) ? 1 : N;
      end
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_fin <= 1'b1;
        m_q   <= p_q;
        m_r   <= p_r;
        m_dbz <= p_dbz;
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_finish", bus.finish, m_fin);
    chk("cyc_quot", bus.quotient_out, m_q);
    chk("cyc_rem", bus.remainder_out, m_r);
    chk("cyc_dbz", bus.div_by_zero, m_dbz);
  end

  task automatic kick(input int a, input int b);
    bus.A_in  = N'(a);
    bus.B_in  = N'(b);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_fin(output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (bus.finish) break;
    end
    if (!bus.finish) chk("timeout", 0, 1);
  endtask

  task automatic run(input int a, input int b, input int l, input int q, input int r, input int z);
    int lat;
    kick(a, b);
    wait_fin(lat);
    chk("lat", lat, l);
    chk("quot", bus.quotient_out, q);
    chk("rem", bus.remainder_out, r);
    chk("dbz", bus.div_by_zero, z);
  endtask

  initial begin
    int lat;
    bus.start = 1'b0;
    bus.A_in  = '0;
    bus.B_in  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_finish", bus.finish, 1);
    chk("rst_quot", bus.quotient_out, 0);
    chk("rst_rem", bus.remainder_out, 0);
    chk("rst_dbz", bus.div_by_zero, 0);

    run(13, 4, 4, 3, 1, 0);
    repeat (5) @(negedge clk);
    chk("hold_quot", bus.quotient_out, 3);
    chk("hold_rem", bus.remainder_out, 1);
    chk("hold_finish", bus.finish, 1);

    run(15, 1, 4, 15, 0, 0);
    run(9, 9, 4, 1, 0, 0);
    run(7, 0, 1, 15, 7, 1);
    run(6, 3, 4, 2, 0, 0);

    kick(14, 3);
    @(negedge clk);
    kick(11, 2);
    chk("abort_busy", bus.finish, 0);
    wait_fin(lat);
    chk("abort_lat", lat, 4);
    chk("abort_quot", bus.quotient_out, 5);
    chk("abort_rem", bus.remainder_out, 1);

    kick(14, 3);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_finish", bus.finish, 1);
    chk("areset_quot", bus.quotient_out, 0);
    chk("areset_rem", bus.remainder_out, 0);
    chk("areset_dbz", bus.div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(3, 9, EARLY ? 1 : 4, 0, 3, 0);

    bus.A_in  = 4'd5;
    bus.B_in  = 4'd2;
    bus.start = 1'b1;
    repeat (4) @(negedge clk);
    chk("hold_start", bus.finish, 0);
    bus.start = 1'b0;
    wait_fin(lat);
    chk("hold_start_lat", lat, 4);
    chk("hold_start_quot", bus.quotient_out, 2);
    chk("hold_start_rem", bus.remainder_out, 1);

    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        kick(a, b);
        wait_fin(lat);
        chk("inv_eq", bus.quotient_out * b + bus.remainder_out, a);
        chk("inv_lt", int'(bus.remainder_out < b), 1);
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
